// File: rtl/definitions_pkg.sv
// Shared type and constant definitions for the RV32I multi-cycle core.
// Holds the immediate-format select, the control FSM state encoding, the
// datapath mux selects, ALU operations, RV32I base opcodes, and a helper
// that maps funct3/funct7[5] to an ALU operation.
package definitions_pkg;

  // Immediate format presented to imm_gen.
  typedef enum logic [2:0] {
    IMM_I_TYPE = 3'd0,
    IMM_S_TYPE = 3'd1,
    IMM_B_TYPE = 3'd2,
    IMM_U_TYPE = 3'd3,
    IMM_JAL    = 3'd4
  } imm_e;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } ctrl_state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    ALU_A_RS1  = 2'd0,
    ALU_A_PC   = 2'd1,
    ALU_A_ZERO = 2'd2
  } alu_a_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct3 -> ALU operation for OP / OP-IMM. 'alt' is funct7[5] (inst[30]).
  // SUB exists only in the register form; in OP-IMM bit 30 of funct3=000 is
  // immediate data. SRA/SRAI share the same encoding in both forms.
  function automatic alu_op_e funct3_alu_op(input logic [2:0] funct3,
                                            input logic       alt,
                                            input logic       is_reg);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// Combinational RV32I instruction decoder.
// Inputs : inst      - instruction register contents
// Outputs: imm_sel   - immediate format for imm_gen
//          alu_op    - ALU operation
//          alu_a_sel - ALU operand A source (RS1 / PC / ZERO)
//          alu_b_sel - ALU operand B source (0 = rs2, 1 = immediate)
//          wb_sel    - register write-back source
//          is_load, is_store, is_branch, is_jump - instruction class
//          legal     - opcode is one of the supported RV32I base opcodes
module inst_decoder
  import definitions_pkg::*;
(
  input  logic [31:0] inst,
  output imm_e        imm_sel,
  output alu_op_e     alu_op,
  output alu_a_e      alu_a_sel,
  output logic        alu_b_sel,
  output wb_sel_e     wb_sel,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jump,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign alt    = inst[30];

  // Remaining fields are immediate or register data handled by the datapath.
  logic unused_fields;
  assign unused_fields = ^{inst[31], inst[29:15], inst[11:7]};

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    imm_sel   = IMM_I_TYPE;
    alu_op    = ALU_ADD;
    alu_a_sel = ALU_A_RS1;
    alu_b_sel = 1'b1;
    wb_sel    = WB_ALU;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    legal     = 1'b1;
    case (opcode)
      OPC_LUI: begin
        imm_sel   = IMM_U_TYPE;
        alu_a_sel = ALU_A_ZERO;
      end
      OPC_AUIPC: begin
        imm_sel   = IMM_U_TYPE;
        alu_a_sel = ALU_A_PC;
      end
      OPC_JAL: begin
        imm_sel   = IMM_JAL;
        alu_a_sel = ALU_A_PC;
        wb_sel    = WB_PC4;
        is_jump   = 1'b1;
      end
      OPC_JALR: begin
        wb_sel  = WB_PC4;
        is_jump = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel   = IMM_B_TYPE;
        alu_a_sel = ALU_A_PC;
        is_branch = 1'b1;
      end
      OPC_LOAD: begin
        wb_sel  = WB_MEM;
        is_load = 1'b1;
      end
      OPC_STORE: begin
        imm_sel  = IMM_S_TYPE;
        is_store = 1'b1;
      end
      OPC_OP_IMM: begin
        alu_op = funct3_alu_op(funct3, alt, 1'b0);
      end
      OPC_OP: begin
        // imm_sel stays I-type; the immediate is simply not used.
        alu_b_sel = 1'b0;
        alu_op    = funct3_alu_op(funct3, alt, 1'b1);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core.
// Sequences FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB) over one shared
// memory port, one instruction in flight. All outputs are combinational
// from the registered state and the instruction register.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   inst                  - instruction register (valid from DECODE)
//   br_taken              - branch comparator result
//   mem_ready             - memory completes the current request
//   mem_req, mem_we       - memory request / store
//   addr_sel              - memory address: 0 = PC, 1 = ALU result
//   ir_we, pc_we, pc_sel  - IR load, PC update, PC source (0 = PC+4, 1 = ALU)
//   reg_we, wb_sel        - register write and write-back source
//   alu_a_sel, alu_b_sel, alu_op, imm_sel - datapath selects
//   illegal               - sticky illegal-opcode flag
//   reset_pc              - RESET_PC constant for the PC reset load
module multicycle_ctrl
  import definitions_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output wb_sel_e     wb_sel,
  output alu_a_e      alu_a_sel,
  output logic        alu_b_sel,
  output alu_op_e     alu_op,
  output imm_e        imm_sel,
  output logic        illegal,
  output logic [31:0] reset_pc
);

  imm_e    dec_imm_sel;
  alu_op_e dec_alu_op;
  alu_a_e  dec_alu_a_sel;
  logic    dec_alu_b_sel;
  wb_sel_e dec_wb_sel;
  logic    dec_is_load;
  logic    dec_is_store;
  logic    dec_is_branch;
  logic    dec_is_jump;
  logic    dec_legal;

  inst_decoder u_inst_decoder (
    .inst      (inst),
    .imm_sel   (dec_imm_sel),
    .alu_op    (dec_alu_op),
    .alu_a_sel (dec_alu_a_sel),
    .alu_b_sel (dec_alu_b_sel),
    .wb_sel    (dec_wb_sel),
    .is_load   (dec_is_load),
    .is_store  (dec_is_store),
    .is_branch (dec_is_branch),
    .is_jump   (dec_is_jump),
    .legal     (dec_legal)
  );

  ctrl_state_e state_q, state_d;
  logic        illegal_q, illegal_d;
  logic        rd_nonzero;

  assign rd_nonzero = |inst[11:7];
  assign reset_pc   = RESET_PC;
  // Reset is synchronous, so the flag must also be masked combinationally
  // during the reset cycle itself.
  assign illegal    = illegal_q & rst_n;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    alu_a_sel = ALU_A_RS1;
    alu_b_sel = 1'b0;
    alu_op    = ALU_ADD;
    imm_sel   = IMM_I_TYPE;

    // While rst_n is low every output stays at its default, whatever the
    // (possibly stale) state register holds.
    if (rst_n) begin
      // Selects follow the IR; it is stable from DECODE until the next
      // fetch completes, which keeps the ALU result valid in MEM and WB.
      wb_sel    = dec_wb_sel;
      alu_a_sel = dec_alu_a_sel;
      alu_b_sel = dec_alu_b_sel;
      alu_op    = dec_alu_op;
      imm_sel   = dec_imm_sel;

      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_legal) begin
            state_d = ST_EXECUTE;
          end else begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end
        end
        ST_EXECUTE: begin
          if (dec_is_branch) begin
            pc_we   = 1'b1;
            pc_sel  = br_taken;
            state_d = ST_FETCH;
          end else if (dec_is_load || dec_is_store) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = dec_is_store;
          if (mem_ready) begin
            if (dec_is_store) begin
              pc_we   = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          reg_we  = rd_nonzero;
          pc_we   = 1'b1;
          pc_sel  = dec_is_jump;
          state_d = ST_FETCH;
        end
        ST_TRAP: begin
          state_d = ST_TRAP;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  import definitions_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we;
  wb_sel_e     wb_sel;
  alu_a_e      alu_a_sel;
  logic        alu_b_sel;
  alu_op_e     alu_op;
  imm_e        imm_sel;
  logic        illegal;
  logic [31:0] reset_pc;

  multicycle_ctrl #(.RESET_PC(TB_RESET_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst      (inst),
    .br_taken  (br_taken),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_op    (alu_op),
    .imm_sel   (imm_sel),
    .illegal   (illegal),
    .reset_pc  (reset_pc)
  );

  always #5 clk = ~clk;

  // One program entry: instruction word, fetch wait cycles, data wait
  // cycles, and the branch outcome the datapath reports for it.
  typedef struct {
    logic [31:0] word;
    int          fw;
    int          mw;
    logic        br;
  } instr_t;

  // One expected output cycle. gap = idle cycles since the previous one.
  typedef struct {
    int      gap;
    logic    mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we;
    bit      chk_wb;
    wb_sel_e wb;
    bit      chk_sel;
    alu_a_e  a;
    logic    b;
    alu_op_e op;
    imm_e    imm;
  } ev_t;

  instr_t prog[$];
  ev_t    exp_q[$];
  int     total = 0;
  int     bad = 0;
  bit     mem_en = 0;
  bit     mon_en = 0;
  int     fetched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic ev_t blank();
    ev_t e;
    e.gap = 0; e.mem_req = 0; e.mem_we = 0; e.addr_sel = 0; e.ir_we = 0;
    e.pc_we = 0; e.pc_sel = 0; e.reg_we = 0; e.chk_wb = 0; e.wb = WB_ALU;
    e.chk_sel = 0; e.a = ALU_A_RS1; e.b = 0; e.op = ALU_ADD; e.imm = IMM_I_TYPE;
    return e;
  endfunction

  function automatic alu_op_e model_op(input logic [31:0] w);
    alu_op_e tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    logic [6:0] opc = w[6:0];
    logic [2:0] f3 = w[14:12];
    if (opc != OPC_OP && opc != OPC_OP_IMM) return ALU_ADD;
    if (opc == OPC_OP && f3 == 3'd0 && w[30]) return ALU_SUB;
    if (f3 == 3'd5 && w[30]) return ALU_SRA;
    return tab[f3];
  endfunction

  // Builds the expected output cycles for one instruction and queues them.
  task automatic add_instr(input logic [31:0] w, input int fw, input int mw, input logic br);
    ev_t e;
    instr_t it;
    logic [6:0] opc = w[6:0];
    logic rd_nz = (w[11:7] != 5'd0);
    bit jump = (opc == OPC_JAL) || (opc == OPC_JALR);
    bit legal_opc = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
    it.word = w; it.fw = fw; it.mw = mw; it.br = br;
    prog.push_back(it);
    for (int k = 0; k <= fw; k++) begin
      e = blank();
      e.mem_req = 1;
      e.ir_we = (k == fw);
      exp_q.push_back(e);
    end
    if (legal_opc) begin
      e = blank();
      e.chk_sel = 1;
      e.a = (opc == OPC_LUI) ? ALU_A_ZERO :
            (opc inside {OPC_AUIPC, OPC_JAL, OPC_BRANCH}) ? ALU_A_PC : ALU_A_RS1;
      e.b = (opc != OPC_OP);
      e.op = model_op(w);
      e.imm = (opc == OPC_STORE) ? IMM_S_TYPE :
              (opc == OPC_BRANCH) ? IMM_B_TYPE :
              (opc == OPC_JAL) ? IMM_JAL :
              (opc inside {OPC_LUI, OPC_AUIPC}) ? IMM_U_TYPE : IMM_I_TYPE;
      if (opc == OPC_BRANCH) begin
        e.gap = 1; e.pc_we = 1; e.pc_sel = br;
        exp_q.push_back(e);
      end else if (opc == OPC_LOAD || opc == OPC_STORE) begin
        for (int k = 0; k <= mw; k++) begin
          e.gap = (k == 0) ? 2 : 0;
          e.mem_req = 1; e.addr_sel = 1; e.mem_we = (opc == OPC_STORE);
          e.pc_we = (opc == OPC_STORE) && (k == mw);
          exp_q.push_back(e);
        end
        if (opc == OPC_LOAD) begin
          e.gap = 0; e.mem_req = 0; e.addr_sel = 0; e.mem_we = 0;
          e.reg_we = rd_nz; e.pc_we = 1; e.pc_sel = 0;
          e.chk_wb = 1; e.wb = WB_MEM;
          exp_q.push_back(e);
        end
      end else begin
        e.gap = 2; e.reg_we = rd_nz; e.pc_we = 1; e.pc_sel = jump;
        e.chk_wb = 1; e.wb = jump ? WB_PC4 : WB_ALU;
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic logic [31:0] gen_rand();
    logic [31:0] r = $urandom;
    logic [2:0]  f3;
    int          idx;
    logic [31:0] w;
    case ($urandom_range(0, 8))
      0: w = {r[31:7], OPC_LUI};
      1: w = {r[31:7], OPC_AUIPC};
      2: w = {r[31:7], OPC_JAL};
      3: w = {r[31:15], 3'b000, r[11:7], OPC_JALR};
      4: begin
        f3 = r[14:12];
        if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
        w = {r[31:15], f3, r[11:7], OPC_BRANCH};
      end
      5: begin
        idx = $urandom_range(0, 4);
        f3 = (idx < 3) ? 3'(idx) : 3'(idx + 1);
        w = {r[31:15], f3, r[11:7], OPC_LOAD};
      end
      6: w = {r[31:15], 3'($urandom_range(0, 2)), r[11:7], OPC_STORE};
      7: begin
        f3 = r[14:12];
        if (f3 == 3'd1) r[31:25] = 7'd0;
        if (f3 == 3'd5) r[31:25] = {1'b0, r[30], 5'd0};
        w = {r[31:15], f3, r[11:7], OPC_OP_IMM};
      end
      default: w = {r[31:7], OPC_OP};
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  // ---------------- memory / IR responder ----------------
  initial begin : memory
    int cnt = 0;
    bit busy = 0;
    bit is_fetch = 0;
    bit complete;
    forever begin
      @(negedge clk);
      complete = 0;
      if (mem_en) begin
        if (mem_req) begin
          if (!busy) begin
            busy = 1;
            is_fetch = !addr_sel;
            if (is_fetch) cnt = (fetched < prog.size()) ? prog[fetched].fw : 0;
            else          cnt = (fetched > 0) ? prog[fetched-1].mw : 0;
          end
          mem_ready = (cnt == 0);
          if (cnt > 0) cnt--;
          complete = mem_ready;
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
      end
      @(posedge clk);
      #1;
      if (complete) begin
        busy = 0;
        if (is_fetch) begin
          if (fetched < prog.size()) begin
            inst = prog[fetched].word;
            br_taken = prog[fetched].br;
          end
          fetched++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int  idle = 0;
    ev_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        idle = 0;
      end else if (mem_req || ir_we || pc_we || reg_we) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          check("gap", idle, e.gap);
          check("mem_req", mem_req, e.mem_req);
          check("mem_we", mem_we, e.mem_we);
          check("addr_sel", addr_sel, e.addr_sel);
          check("ir_we", ir_we, e.ir_we);
          check("pc_we", pc_we, e.pc_we);
          check("pc_sel", pc_sel, e.pc_sel);
          check("reg_we", reg_we, e.reg_we);
          check("illegal", illegal, 0);
          if (e.chk_wb) check("wb_sel", wb_sel, e.wb);
          if (e.chk_sel) begin
            check("alu_a_sel", alu_a_sel, e.a);
            check("alu_b_sel", alu_b_sel, e.b);
            check("alu_op", alu_op, e.op);
            check("imm_sel", imm_sel, e.imm);
          end
        end
        idle = 0;
      end else begin
        idle++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int c;
    add_instr(32'h0050_0093, 0, 0, 1'b0); // ADDI x1,x0,5
    add_instr(32'h0040_a103, 0, 3, 1'b0); // LW x2,4(x1), 3 wait cycles in MEM
    add_instr(32'h0000_0063, 0, 0, 1'b1); // BEQ taken
    add_instr(32'h0020_8463, 1, 0, 1'b0); // BEQ not taken, slow fetch
    add_instr(32'h0080_006f, 0, 0, 1'b0); // JAL x0,8
    add_instr(32'h0020_a223, 0, 2, 1'b0); // SW x2,4(x1)
    add_instr(32'h4020_81b3, 0, 0, 1'b0); // SUB x3,x1,x2
    add_instr(32'h4030_d213, 0, 0, 1'b0); // SRAI x4,x1,3
    for (int i = 0; i < 40; i++)
      add_instr(gen_rand(), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    add_instr(32'h0000_0000, 0, 0, 1'b0); // illegal opcode -> TRAP

    // Reset held 3 cycles with mem_ready high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      check("rst_mem_req", mem_req, 0);
      check("rst_enables", {ir_we, pc_we, reg_we, mem_we}, 0);
      check("rst_illegal", illegal, 0);
    end
    check("reset_pc", reset_pc, TB_RESET_PC);
    @(posedge clk);
    #1;
    rst_n = 1;
    mem_en = 1;
    mon_en = 1;
    @(negedge clk);
    #2;
    check("first_fetch_req", mem_req, 1);
    check("first_fetch_addr", addr_sel, 0);

    c = 0;
    while (exp_q.size() != 0 && c < 20000) begin
      @(negedge clk);
      #3;
      c++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");

    // DECODE of the illegal word, then TRAP must hold with nothing enabled.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      check("trap_illegal", illegal, 1);
      check("trap_enables", {mem_req, ir_we, pc_we, reg_we, mem_we}, 0);
    end

    // One reset cycle leaves TRAP and restarts fetching.
    mon_en = 0;
    mem_en = 0;
    @(posedge clk);
    #1;
    rst_n = 0;
    mem_ready = 1;
    @(negedge clk);
    #2;
    check("rst2_illegal", illegal, 0);
    check("rst2_mem_req", mem_req, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    #2;
    check("resume_mem_req", mem_req, 1);
    check("resume_addr_sel", addr_sel, 0);
    check("resume_ir_we", ir_we, 1);
    check("resume_illegal", illegal, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core; sequences fetch, decode, execute, memory and writeback over a single shared memory port.
- Drives the immediate generator select (imm_sel), ALU operand/op selects, PC/IR/register-file write enables and writeback mux.
- Sits between the instruction register/branch comparator and the datapath muxes. One instruction in flight; no pipelining.

Parameters:
- RESET_PC, 32'h0000_0000, value presented on reset_pc for the datapath PC register load during reset

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- inst  in  32  instruction register contents; valid from DECODE onward
- br_taken  in  1  branch comparator result for current BRANCH (funct3-evaluated by datapath)
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  request is a store
- addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  update PC
- pc_sel  out  1  0 = PC+4, 1 = ALU result (datapath clears bit 0 for JALR)
- reg_we  out  1  register file write
- wb_sel  out  wb_sel_e  ALU / MEM / PC4
- alu_a_sel  out  alu_a_e  RS1 / PC / ZERO
- alu_b_sel  out  1  0 = rs2, 1 = imm_data
- alu_op  out  alu_op_e  ALU operation
- imm_sel  out  imm_e  immediate format to imm_gen
- illegal  out  1  sticky illegal-opcode flag
- reset_pc  out  32  RESET_PC constant

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Registered state; all outputs combinational from state and inst.
- Reset: any cycle with rst_n=0 forces state to FETCH, clears illegal, and drives all outputs low/default (mem_req=0, every *_we=0). First FETCH request appears in the first cycle with rst_n=1. Reset mid-MEM or mid-FETCH aborts the request; memory tolerates the dropped request.
- FETCH: mem_req=1, addr_sel=PC, mem_we=0. Holds while mem_ready=0. When mem_ready=1: ir_we=1 in that cycle, then go to DECODE.
- DECODE: exactly 1 cycle; imm_sel is valid from here.
  - Opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}: go to TRAP, illegal=1.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - BRANCH: alu_a=PC, b=imm, ADD. pc_we=1, pc_sel=br_taken. Next state FETCH.
  - LOAD/STORE: alu_a=RS1, b=imm, ADD. Next state MEM.
  - All others: next state WB. Operand selects:
    - LUI: ZERO + imm.
    - AUIPC and JAL: PC + imm.
    - JALR: RS1 + imm.
    - OP-IMM: RS1 op imm.
    - OP: RS1 op rs2.
- MEM: mem_req=1, addr_sel=ALU, mem_we=(STORE). Holds until mem_ready.
  - LOAD then goes to WB.
  - STORE: pc_we=1, pc_sel=PC+4, then FETCH.
- WB: reg_we=(rd!=0).
  - wb_sel: MEM for LOAD; PC4 for JAL/JALR; ALU otherwise.
  - pc_we=1; pc_sel=ALU for JAL/JALR, else PC+4.
  - Next state FETCH.
- TRAP: absorbing; all enables 0; exit only by reset.
- ALU inputs are held stable from EXECUTE through MEM/WB, so ALU results stay valid for address and target use.
- alu_op decode:
  - ADD for address, branch-target, LUI, AUIPC, JAL and JALR.
  - OP/OP-IMM use funct3.
  - SUB only for OP with funct7[5]=1; SRA when funct3=101 and funct7[5]=1 (both formats).
- imm_sel mapping:
  - I-type for OP-IMM, LOAD and JALR.
  - STORE, BRANCH and JAL use their own formats.
  - U-type for LUI and AUIPC.
  - OP drives IMM_I_TYPE (unused).
- Latency per instruction type (each count includes the FETCH cycle, with mem_ready immediate):
  - BRANCH: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- mem_ready while mem_req=0 is ignored.

Decomposition:
- definitions_pkg gains:
  - ctrl_state_e, wb_sel_e, alu_a_e, alu_op_e.
  - Opcode localparams OPC_LUI … OPC_OP.
  - Existing imm_e is reused.
- One sub-module, inst_decoder: combinational, inst → {imm_sel, alu_op, alu_a_sel, alu_b_sel, wb_sel, is_load, is_store, is_branch, is_jump, legal}.
- The FSM lives in multicycle_ctrl.

Test Plan:
- Reset held 3 cycles, mem_ready=1 → mem_req=0 during reset; mem_req=1 with addr_sel=PC on the first cycle after release.
- ADDI x1,x0,5 (32'h00500093), mem_ready always 1 → FETCH/DECODE/EXECUTE/WB in 4 cycles.
  - imm_sel=IMM_I_TYPE, alu_op=ADD, alu_b_sel=1.
  - WB cycle: reg_we=1, pc_we=1.
- LW x2,4(x1) with mem_ready low 3 extra cycles in MEM → mem_req held for 4 cycles with addr_sel=1, mem_we=0.
  - Then WB with wb_sel=MEM; 8 cycles total.
- BEQ with br_taken=1 and br_taken=0 → EXECUTE asserts pc_we with pc_sel=1 or 0 respectively; no reg_we; returns to FETCH.
- JAL x0,… (rd=0) → reg_we=0 in WB, wb_sel=PC4, pc_sel=1, imm_sel=IMM_JAL.
- inst=32'h0000_0000 → TRAP after DECODE, illegal=1 held for 10 cycles with all enables 0; rst_n low for one cycle clears it and FETCH resumes.
